sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Two-port arbiter sharing the single byte-wide SDRAM controller between the CPU path (memctrl, port 0) and the SD-card sector DMA (port 1).
- Sits between the requesters and the sdram unit, on the 25 MHz CPU clock domain.
- Serialises byte transactions with a req/ack handshake, round-robin fairness and a watchdog against a hung controller.

Parameters:
- AW, 26, byte address width (64 MB SDRAM).
- DW, 8, data width.
- TIMEOUT, 255, maximum cycles in WAIT before the watchdog fires; must be ≥ 2.

Ports:
- clock  in  1  CPU clock (25 MHz).
- reset_n  in  1  asynchronous active-low reset.
- p0_req  in  1  port 0 request; held high until p0_ack.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  AW  port 0 byte address.
- p0_wdata  in  DW  port 0 write data.
- p0_rdata  out  DW  port 0 read data; valid with p0_ack.
- p0_ack  out  1  port 0 one-cycle completion pulse.
- p1_req, p1_we, p1_addr, p1_wdata, p1_rdata, p1_ack: same set for port 1.
- mem_req  out  1  request to the SDRAM controller; held until mem_ack.
- mem_we  out  1  write strobe to the controller.
- mem_addr  out  AW  address to the controller.
- mem_wdata  out  DW  write data to the controller.
- mem_rdata  in  DW  read data from the controller; valid with mem_ack.
- mem_ack  in  1  controller one-cycle completion pulse.
- busy  out  1  high in any state other than IDLE.
- grant  out  1  index of the port currently or last served.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction; no completion pulse is emitted):
  - state=IDLE, last_grant=1 so port 0 wins the first tie.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, pX_ack, pX_rdata, busy, grant, timeout_err.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: sample the requests.
  - None pending: stay in IDLE.
  - One pending: grant that port.
  - Both pending: grant the port != last_grant.
  - On a grant: latch the winner's we/addr/wdata into the mem_* registers, set grant and last_grant, go to ISSUE.
- ISSUE: mem_req=1 (registered). Go to WAIT. Latency from pX_req sampled in IDLE to mem_req high is 1 cycle.
- WAIT: mem_req stays high, command fields stable.
  - Counter counts up from 0 each cycle.
  - mem_ack=1: latch mem_rdata into the granted pX_rdata, drop mem_req, go to RESP.
  - Counter reaches TIMEOUT before mem_ack: drop mem_req, load pX_rdata=all-ones, set timeout_err, go to RESP.
- RESP: granted pX_ack=1 for exactly one cycle, then IDLE.
  - The requester must deassert req at the edge ending RESP. A req still high in IDLE is a new transaction.
- Read-data hold: pX_rdata holds its value until that port's next completion. Writes leave pX_rdata unchanged, except on timeout, where all-ones is loaded.
- Ack latency: pX_ack rises 1 cycle after mem_ack. Minimum transaction length is 4 cycles, i.e. ISSUE + one WAIT cycle with ack + RESP + IDLE.
- Requests arriving outside IDLE are not lost; the requester simply holds req.
- mem_ack outside WAIT is ignored.
- Simultaneous mem_ack and counter==TIMEOUT: the ack wins; no error is raised.
- timeout_err is cleared only by reset.
- Counter width is clog2(TIMEOUT+1); it must not wrap inside WAIT.

Optional Feature:
- Macro: SDRAM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins ties and last_grant is ignored. Port 1 can starve, which is acceptable while the CPU is latency-critical.
- Undefined: round-robin as described above.

Decomposition:
- Shared include sdram_arb_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_WAIT=2'd2, ST_RESP=2'd3;
  - the timeout fill value;
  - port index constants PORT_CPU=0, PORT_DMA=1.
- No sub-module: the two-way tie-break is a few lines. A single flat module is required.

Test Plan:
- Single read on p0 at addr 26'h000123; model returns 8'h5A after 3 WAIT cycles -> mem_req high 1 cycle after req; mem_addr=26'h000123, mem_we=0; p0_ack one cycle later with p0_rdata=8'h5A; p1_ack stays 0.
- p0 and p1 request in the same cycle, both held for 4 transactions -> grant order 0,1,0,1 after reset. With SDRAM_ARB_FIXED_PRIO_EN defined: port 0 served while p0_req is re-asserted, p1 only when p0 idle.
- p1 write 8'hC3 to 26'h3FFFFFF -> mem_we=1, mem_wdata=8'hC3, mem_addr=26'h3FFFFFF stable across all of WAIT; p1_rdata unchanged.
- Model never acks, TIMEOUT=255 -> mem_req drops after 255 WAIT cycles; p0_ack pulses with p0_rdata=8'hFF; timeout_err=1 and stays 1 through the next good transaction.
- reset_n asserted during WAIT -> mem_req, busy and grant go 0 immediately without a clock edge; no pX_ack. After release, a p1 request is served normally.
- mem_ack on the same cycle as counter==TIMEOUT, plus a spurious mem_ack in IDLE -> normal completion with the model data and timeout_err=0; the spurious ack is ignored with no pX_ack.

Source files
------------

// File: rtl/sdram_arbiter_pkg.sv
// Shared definitions for the two-port SDRAM arbiter: FSM encoding, port indices, tie-break.
// The tie-break changes to fixed port-0 priority when SDRAM_ARB_FIXED_PRIO_EN is defined.
`timescale 1ns/1ps
package sdram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  // Read data reported to the requester when the controller never answers.
  localparam logic TIMEOUT_FILL_BIT = 1'b1;

  function automatic logic pick_winner(input logic req0, input logic req1,
                                       input logic last_grant);
    logic win;
    if (req0 && req1) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      win = PORT_CPU;
`else
      win = ~last_grant;
`endif
    end else if (req1) begin
      win = PORT_DMA;
    end else begin
      win = PORT_CPU;
    end
    return win;
  endfunction

endpackage

// File: rtl/sdram_arbiter.sv
// Two-port byte arbiter in front of the SDRAM controller with req/ack handshakes and a watchdog.
// Optional macro SDRAM_ARB_FIXED_PRIO_EN: port 0 always wins ties instead of round-robin.
`timescale 1ns/1ps
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int AW      = 26,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_ack,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic          grant,
  output logic          timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // The counter holds completed WAIT cycles; the watchdog fires as it would reach TIMEOUT.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_t    state, state_nxt;
  logic          last_grant, last_grant_nxt, grant_nxt, winner;
  logic          mem_req_nxt, mem_we_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_wdata_nxt, p0_rdata_nxt, p1_rdata_nxt;
  logic          p0_ack_nxt, p1_ack_nxt, timeout_err_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  assign busy   = (state != ST_IDLE);
  assign winner = pick_winner(p0_req, p1_req, last_grant);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      last_grant  <= PORT_DMA;
      grant       <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
      p0_ack      <= 1'b0;
      p1_ack      <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_nxt;
      last_grant  <= last_grant_nxt;
      grant       <= grant_nxt;
      mem_req     <= mem_req_nxt;
      mem_we      <= mem_we_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_wdata   <= mem_wdata_nxt;
      p0_rdata    <= p0_rdata_nxt;
      p1_rdata    <= p1_rdata_nxt;
      p0_ack      <= p0_ack_nxt;
      p1_ack      <= p1_ack_nxt;
      timeout_err <= timeout_err_nxt;
      cnt         <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    last_grant_nxt  = last_grant;
    grant_nxt       = grant;
    mem_req_nxt     = mem_req;
    mem_we_nxt      = mem_we;
    mem_addr_nxt    = mem_addr;
    mem_wdata_nxt   = mem_wdata;
    p0_rdata_nxt    = p0_rdata;
    p1_rdata_nxt    = p1_rdata;
    p0_ack_nxt      = 1'b0;
    p1_ack_nxt      = 1'b0;
    timeout_err_nxt = timeout_err;
    cnt_nxt         = cnt;
    case (state)
      ST_IDLE: begin
        // mem_req is raised on the grant edge so it is already high throughout ISSUE.
        if (p0_req || p1_req) begin
          state_nxt      = ST_ISSUE;
          grant_nxt      = winner;
          last_grant_nxt = winner;
          mem_req_nxt    = 1'b1;
          mem_we_nxt     = (winner == PORT_DMA) ? p1_we    : p0_we;
          mem_addr_nxt   = (winner == PORT_DMA) ? p1_addr  : p0_addr;
          mem_wdata_nxt  = (winner == PORT_DMA) ? p1_wdata : p0_wdata;
        end
      end
      ST_ISSUE: begin
        state_nxt = ST_WAIT;
        cnt_nxt   = '0;
      end
      ST_WAIT: begin
        // An ack in the final watchdog cycle still counts as a normal completion.
        if (mem_ack || cnt == CNT_LAST) begin
          state_nxt   = ST_RESP;
          mem_req_nxt = 1'b0;
          if (grant == PORT_DMA) p1_ack_nxt = 1'b1;
          else                   p0_ack_nxt = 1'b1;
          if (!mem_ack) begin
            timeout_err_nxt = 1'b1;
            if (grant == PORT_DMA) p1_rdata_nxt = {DW{TIMEOUT_FILL_BIT}};
            else                   p0_rdata_nxt = {DW{TIMEOUT_FILL_BIT}};
          end else if (!mem_we) begin
            if (grant == PORT_DMA) p1_rdata_nxt = mem_rdata;
            else                   p0_rdata_nxt = mem_rdata;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: transaction timeline model plus randomized traffic.
// Honours SDRAM_ARB_FIXED_PRIO_EN when predicting tie-breaks.
`timescale 1ns/1ps
module tb_sdram_arbiter;

  localparam int AW      = 26;
  localparam int DW      = 8;
  localparam int TIMEOUT = 255;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
  logic          p0_ack, p1_ack;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, grant, timeout_err;

  sdram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_ack(p1_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .grant(grant), .timeout_err(timeout_err)
  );

  always #20 clock = ~clock;

  // delay: WAIT cycle in which the controller acks; 0 or >TIMEOUT means it never does.
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            delay;
    logic [DW-1:0] rdval;
    int            gap;
  } txn_t;

  txn_t          pq [2][$];
  bit            holding [2];
  int            gap_cnt [2];
  int            e, tot, bad, n;
  bit            spur_en;

  // Transaction timeline: granted on edge m_g, command held until m_done, ack pulse after m_done.
  bit            m_active, m_to, m_cur, m_last, m_grant, m_terr;
  int            m_g, m_w, m_done;
  txn_t          m_t;
  logic [DW-1:0] exp_rdata [2];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic applyStimulus(input int port, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input int delay,
                               input logic [DW-1:0] rdval, input int gap);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata; t.delay = delay; t.rdval = rdval; t.gap = gap;
    if (pq[port].size() == 0 && !holding[port]) gap_cnt[port] = gap;
    pq[port].push_back(t);
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_last = 1'b1; m_grant = 1'b0; m_terr = 1'b0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    for (int i = 0; i < 2; i++) begin
      holding[i] = 1'b0; gap_cnt[i] = 0; pq[i].delete();
    end
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic model_update();
    bit w;
    if (m_active) begin
      if (e == m_done) begin
        if (m_to) begin
          exp_rdata[m_cur] = '1;
          m_terr = 1'b1;
        end else if (!m_t.we) begin
          exp_rdata[m_cur] = m_t.rdval;
        end
      end else if (e == m_done + 1) begin
        m_active = 1'b0;
      end
    end else if (holding[0] || holding[1]) begin
      if (holding[0] && holding[1]) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        w = 1'b0;
`else
        w = ~m_last;
`endif
      end else begin
        w = holding[1];
      end
      m_cur = w; m_last = w; m_grant = w;
      m_t = pq[w][0];
      m_g = e;
      m_to = (m_t.delay < 1 || m_t.delay > TIMEOUT);
      m_w = m_to ? TIMEOUT : m_t.delay;
      m_done = m_g + m_w + 1;
      m_active = 1'b1;
    end
  endtask

  task automatic check_all();
    bit exp_mreq;
    exp_mreq = m_active && (e < m_done);
    checkOutput("mem_req", 32'(mem_req), 32'(exp_mreq));
    checkOutput("p0_ack", 32'(p0_ack), 32'(m_active && e == m_done && m_cur == 1'b0));
    checkOutput("p1_ack", 32'(p1_ack), 32'(m_active && e == m_done && m_cur == 1'b1));
    checkOutput("busy", 32'(busy), 32'(m_active));
    checkOutput("grant", 32'(grant), 32'(m_grant));
    checkOutput("p0_rdata", 32'(p0_rdata), 32'(exp_rdata[0]));
    checkOutput("p1_rdata", 32'(p1_rdata), 32'(exp_rdata[1]));
    checkOutput("timeout_err", 32'(timeout_err), 32'(m_terr));
    if (exp_mreq) begin
      checkOutput("mem_we", 32'(mem_we), 32'(m_t.we));
      checkOutput("mem_addr", 32'(mem_addr), 32'(m_t.addr));
      checkOutput("mem_wdata", 32'(mem_wdata), 32'(m_t.wdata));
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (holding[i]) begin
        if (m_active && e == m_done && m_cur == 1'(i)) begin
          holding[i] = 1'b0;
          void'(pq[i].pop_front());
          if (pq[i].size() > 0) gap_cnt[i] = pq[i][0].gap;
        end
      end else if (pq[i].size() > 0) begin
        if (gap_cnt[i] == 0) holding[i] = 1'b1;
        else gap_cnt[i]--;
      end
    end
    p0_req = holding[0];
    if (holding[0]) begin
      p0_we = pq[0][0].we; p0_addr = pq[0][0].addr; p0_wdata = pq[0][0].wdata;
    end else begin
      p0_we = 1'($urandom); p0_addr = AW'($urandom); p0_wdata = DW'($urandom);
    end
    p1_req = holding[1];
    if (holding[1]) begin
      p1_we = pq[1][0].we; p1_addr = pq[1][0].addr; p1_wdata = pq[1][0].wdata;
    end else begin
      p1_we = 1'($urandom); p1_addr = AW'($urandom); p1_wdata = DW'($urandom);
    end
    // Controller model: real ack in the planned WAIT cycle, optional stray acks elsewhere.
    mem_ack = 1'b0;
    mem_rdata = DW'($urandom);
    if (m_active && !m_to && e == m_g + m_w) begin
      mem_ack = 1'b1;
      mem_rdata = m_t.rdval;
    end else if (spur_en && !(m_active && e >= m_g + 1 && e <= m_g + m_w)
                 && $urandom_range(0, 3) == 0) begin
      mem_ack = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    e++;
    model_update();
    check_all();
    drive();
  endtask

  task automatic run_until_idle(input int budget);
    int k;
    k = 0;
    while ((pq[0].size() > 0 || pq[1].size() > 0 || m_active) && k < budget) begin
      step();
      k++;
    end
    if (k >= budget) checkOutput("drain_budget", 32'(k), 32'(0));
    repeat (2) step();
  endtask

  initial begin
    #1200000;
    $display("[TB] FAIL global_watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    tot = 0; bad = 0; e = 0; spur_en = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #5;
    checkOutput("rst_mem_req", 32'(mem_req), 32'(0));
    checkOutput("rst_mem_we", 32'(mem_we), 32'(0));
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'(0));
    checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    checkOutput("rst_p0_ack", 32'(p0_ack), 32'(0));
    checkOutput("rst_p1_ack", 32'(p1_ack), 32'(0));
    checkOutput("rst_p0_rdata", 32'(p0_rdata), 32'(0));
    checkOutput("rst_p1_rdata", 32'(p1_rdata), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_grant", 32'(grant), 32'(0));
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'(0));
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Both ports contend from reset: alternating service (or port-0 first when fixed priority).
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 1'b0, AW'($urandom), DW'($urandom), 2, DW'($urandom), 0);
      applyStimulus(1, 1'b0, AW'($urandom), DW'($urandom), 2, DW'($urandom), 0);
    end
    run_until_idle(200);

    applyStimulus(0, 1'b0, 26'h000123, 8'h00, 3, 8'h5A, 0);
    run_until_idle(100);
    applyStimulus(1, 1'b1, 26'h3FFFFFF, 8'hC3, 4, 8'h77, 0);
    run_until_idle(100);

    // Controller hangs, then a good transaction: error flag must stay set.
    applyStimulus(0, 1'b0, 26'h0000AA, 8'h00, 0, 8'h00, 0);
    applyStimulus(0, 1'b0, 26'h0000AB, 8'h00, 2, 8'h42, 1);
    run_until_idle(700);

    // Asynchronous reset in the middle of WAIT.
    applyStimulus(0, 1'b0, 26'h0000001, 8'h00, 20, 8'h11, 0);
    n = 0;
    while (!(m_active && e >= m_g + 2 && e < m_g + m_w) && n < 50) begin
      step();
      n++;
    end
    checkOutput("mid_wait_busy", 32'(busy), 32'(1));
    #10;
    reset_n = 1'b0;
    #1;
    checkOutput("async_mem_req", 32'(mem_req), 32'(0));
    checkOutput("async_busy", 32'(busy), 32'(0));
    checkOutput("async_grant", 32'(grant), 32'(0));
    checkOutput("async_p0_ack", 32'(p0_ack), 32'(0));
    checkOutput("async_timeout_err", 32'(timeout_err), 32'(0));
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(1, 1'b0, 26'h0000002, 8'h00, 2, 8'h99, 0);
    run_until_idle(100);

    // Stray acks while idle, then an ack landing exactly on the watchdog cycle.
    spur_en = 1'b1;
    repeat (12) step();
    applyStimulus(0, 1'b0, 26'h0000003, 8'h00, TIMEOUT, 8'hE7, 0);
    run_until_idle(700);

    for (int k = 0; k < 40; k++) begin
      applyStimulus(int'($urandom_range(0, 1)), 1'($urandom), AW'($urandom), DW'($urandom),
                    ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 6)),
                    DW'($urandom), int'($urandom_range(0, 3)));
    end
    run_until_idle(15000);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
